// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the execute stage and the multiply/divide unit.
//   start, op, src1, src2, cancel : request side, driven by the execute stage
//   ready, busy, done             : status decoded from the unit's state
//   hi, lo                        : registered HI/LO result values
// master = execute stage, slave = muldiv_unit.
interface muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] src1;
    logic [WIDTH-1:0] src2;
    logic             cancel;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, src1, src2, cancel,
        input  ready, busy, done, hi, lo
    );

    modport slave (
        input  start, op, src1, src2, cancel,
        output ready, busy, done, hi, lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative shared multiply/divide unit (one bit per cycle, WIDTH iterations).
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : muldiv_unit_if.slave
//          op 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//          src1 multiplicand/dividend, src2 multiplier/divisor
//          hi = product upper half / remainder, lo = product lower half / quotient
//          ready (IDLE|DONE), busy (MUL|DIV), done (one-cycle DONE pulse)
//          cancel aborts any in-flight operation without touching hi/lo.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       rst,
    muldiv_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state, state_next;

    logic [CW-1:0]        cnt;
    logic [2*WIDTH-1:0]   acc;        // MUL: {partial sum, multiplier}; DIV: {remainder, dividend/quotient}
    logic [2*WIDTH-1:0]   acc_next;
    logic [WIDTH-1:0]     operand;    // multiplicand or divisor magnitude
    logic                 neg_res;    // negate product / quotient
    logic                 neg_rem;    // negate remainder (dividend was negative)
    logic [WIDTH-1:0]     hi_q, lo_q;

    // Request decode
    logic             ready_s;
    logic             accept;
    logic             op_div, op_signed;
    logic             src1_neg, src2_neg;
    logic [WIDTH-1:0] mag1, mag2;
    logic             early_mul, early_div, early;

    // Iteration datapath
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_upper;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] div_next;
    logic               last_iter;
    logic               running;

    // Final sign fix-up
    logic [2*WIDTH-1:0] prod_fin;
    logic [WIDTH-1:0]   quo_fin, rem_fin;

    assign ready_s   = (state == IDLE) || (state == DONE);
    assign running   = (state == MUL) || (state == DIV);
    assign accept    = bus.start && ready_s && !bus.cancel;

    assign op_div    = bus.op[1];
    assign op_signed = !bus.op[0];
    assign src1_neg  = op_signed && bus.src1[WIDTH-1];
    assign src2_neg  = op_signed && bus.src2[WIDTH-1];
    assign mag1      = src1_neg ? -bus.src1 : bus.src1;
    assign mag2      = src2_neg ? -bus.src2 : bus.src2;

    assign early_mul = !op_div && ((bus.src1 == '0) || (bus.src2 == '0));
    assign early_div = op_div && (bus.src2 == '0);
    assign early     = early_mul || early_div;

    assign last_iter = (cnt == CW'(1));

    // Shift-add step: conditionally add multiplicand to the upper half,
    // then shift the whole accumulator right, keeping the carry.
    assign mul_sum  = acc[0] ? ({1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, operand})
                             : {1'b0, acc[2*WIDTH-1:WIDTH]};
    assign mul_next = {mul_sum, acc[WIDTH-1:1]};

    // Restoring step on the left-shifted accumulator. The remainder is always
    // below the divisor, so the shifted value fits in WIDTH+1 bits and the
    // borrow bit of the trial subtraction decides the quotient bit.
    assign div_upper = acc[2*WIDTH-1:WIDTH-1];
    assign div_diff  = div_upper - {1'b0, operand};
    assign div_next  = div_diff[WIDTH] ? {div_upper[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                       : {div_diff[WIDTH-1:0],  acc[WIDTH-2:0], 1'b1};

    always_comb begin
        acc_next = mul_next;
        if (state == DIV) begin
            acc_next = div_next;
        end
    end

    assign prod_fin = neg_res ? -acc_next : acc_next;
    assign quo_fin  = neg_res ? -acc_next[WIDTH-1:0] : acc_next[WIDTH-1:0];
    assign rem_fin  = neg_rem ? -acc_next[2*WIDTH-1:WIDTH] : acc_next[2*WIDTH-1:WIDTH];

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: begin
                state_next = IDLE;
                if (accept) begin
                    if (early) begin
                        state_next = DONE;
                    end else if (op_div) begin
                        state_next = DIV;
                    end else begin
                        state_next = MUL;
                    end
                end
            end
            MUL, DIV: begin
                if (last_iter) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (bus.cancel) begin
            state_next = IDLE;
        end
    end

    // Datapath and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            acc     <= '0;
            operand <= '0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else if (accept) begin
            cnt     <= early ? '0 : CW'(WIDTH);
            acc     <= {{WIDTH{1'b0}}, (op_div ? mag1 : mag2)};
            operand <= op_div ? mag2 : mag1;
            neg_res <= src1_neg ^ src2_neg;
            neg_rem <= src1_neg;
            if (early_mul) begin
                hi_q <= '0;
                lo_q <= '0;
            end else if (early_div) begin
                hi_q <= bus.src1;
                lo_q <= '1;
            end
        end else if (running) begin
            if (bus.cancel) begin
                cnt <= '0;
            end else begin
                acc <= acc_next;
                cnt <= cnt - CW'(1);
                if (last_iter) begin
                    if (state == DIV) begin
                        hi_q <= rem_fin;
                        lo_q <= quo_fin;
                    end else begin
                        hi_q <= prod_fin[2*WIDTH-1:WIDTH];
                        lo_q <= prod_fin[WIDTH-1:0];
                    end
                end
            end
        end
    end

    assign bus.ready = ready_s;
    assign bus.busy  = running;
    assign bus.done  = (state == DONE);
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit (WIDTH=32): stimulus pushes expected
// {hi,lo} computed with plain 64-bit arithmetic; a monitor pops on done.
module tb_muldiv_unit;
    localparam int W = 32;

    logic clk;
    logic rst;

    muldiv_unit_if #(.WIDTH(W)) bus ();

    muldiv_unit #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    logic [63:0] exp_q[$];
    logic [63:0] last_res = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference: {hi, lo} from the arithmetic definition of each operation.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] ua, ub, res;
        ua = {32'b0, a};
        ub = {32'b0, b};
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            2'b00: res = sa * sb;
            2'b01: res = ua * ub;
            default: begin
                if (b == 32'd0) begin
                    res = {a, 32'hFFFF_FFFF};
                end else if (o == 2'b10) begin
                    q = sa / sb;
                    r = sa % sb;
                    res = {r[31:0], q[31:0]};
                end else begin
                    res = {32'(ua % ub), 32'(ua / ub)};
                end
            end
        endcase
        return res;
    endfunction

    function automatic int latency(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        if (!o[1] && (a == 0 || b == 0)) return 1;
        if (o[1] && b == 0) return 1;
        return W + 1;
    endfunction

    // Presents a request for one cycle; operands are scrambled afterwards.
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input bit push);
        bus.start = 1'b1;
        bus.op    = o;
        bus.src1  = a;
        bus.src2  = b;
        if (push) begin
            exp_q.push_back(model(o, a, b));
            last_res = model(o, a, b);
        end
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.op    = 2'($urandom);
        bus.src1  = $urandom;
        bus.src2  = $urandom;
    endtask

    // Called in cycle 1 (posedge+1); returns at the negedge of the done cycle.
    task automatic wait_done(input string name, input int exp_cyc);
        int  k = 1;
        bit  seen = 0;
        bit  busy_ok = 1;
        while (k <= exp_cyc + 5) begin
            @(negedge clk);
            if (bus.done) begin
                seen = 1;
                break;
            end
            if (bus.busy !== 1'b1 || bus.ready !== 1'b0) busy_ok = 0;
            @(posedge clk); #1;
            k++;
        end
        check({name, "_latency"}, 64'(seen ? k : -1), 64'(exp_cyc));
        check({name, "_busy_window"}, 64'(busy_ok), 64'd1);
        if (seen) check({name, "_done_status"}, {62'd0, bus.busy, bus.ready}, 64'd1);
    endtask

    task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        issue(o, a, b, 1);
        wait_done(name, latency(o, a, b));
    endtask

    task automatic to_next_cycle();
        @(posedge clk); #1;
    endtask

    task automatic expect_no_done(input string name, input int cycles);
        int cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (bus.done) cnt++;
        end
        check(name, 64'(cnt), 64'd0);
        to_next_cycle();
    endtask

    // Monitor
    always @(negedge clk) begin
        if (!rst && bus.done) begin
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL unexpected_done: hi=%h lo=%h with nothing expected", bus.hi, bus.lo);
            end else begin
                check("result", {bus.hi, bus.lo}, exp_q.pop_front());
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  o;
        logic [31:0] a, b;
        int mode;

        rst = 1'b1;
        bus.start = 1'b0; bus.cancel = 1'b0; bus.op = 2'b00;
        bus.src1 = '0; bus.src2 = '0;
        #23;
        check("reset_status", {61'd0, bus.ready, bus.busy, bus.done}, 64'b100);
        check("reset_hilo", {bus.hi, bus.lo}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        to_next_cycle();

        run_op("mult_neg", 2'b00, 32'hFFFF_FFFF, 32'd7);
        to_next_cycle();
        run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("mult_b2b", 2'b00, 32'h8000_0000, 32'h8000_0000);
        to_next_cycle();

        run_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2);
        run_op("divu", 2'b11, 32'hFFFF_FFF9, 32'd2);
        run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        to_next_cycle();

        run_op("divu_zero", 2'b11, 32'd5, 32'd0);
        to_next_cycle();
        run_op("div_zero_neg", 2'b10, 32'h8000_0003, 32'd0);
        to_next_cycle();
        run_op("mult_zero", 2'b00, 32'd0, 32'h1234);
        to_next_cycle();

        // Cancel mid-divide: result registers keep the last completed value.
        issue(2'b10, 32'd1000, 32'd7, 0);
        repeat (9) to_next_cycle();
        bus.cancel = 1'b1;
        to_next_cycle();
        bus.cancel = 1'b0;
        check("cancel_status", {62'd0, bus.ready, bus.busy}, 64'b10);
        check("cancel_hilo", {bus.hi, bus.lo}, last_res);
        expect_no_done("cancel_no_done", 40);

        // Start together with cancel is dropped.
        bus.cancel = 1'b1;
        issue(2'b01, 32'd9, 32'd9, 0);
        bus.cancel = 1'b0;
        check("start_cancel_status", {62'd0, bus.ready, bus.busy}, 64'b10);
        expect_no_done("start_cancel_no_done", 40);

        // Asynchronous reset in the middle of a multiply.
        issue(2'b00, 32'h1234_5678, 32'h9ABC_DEF0, 0);
        repeat (14) to_next_cycle();
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_status", {61'd0, bus.ready, bus.busy, bus.done}, 64'b100);
        check("async_rst_hilo", {bus.hi, bus.lo}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        to_next_cycle();
        run_op("multu_after_rst", 2'b01, 32'd3, 32'd5);
        to_next_cycle();

        // Randomized operations, sometimes back-to-back.
        for (int i = 0; i < 30; i++) begin
            o = 2'($urandom);
            a = $urandom;
            b = $urandom;
            mode = $urandom_range(0, 9);
            if (mode == 0) a = 32'd0;
            else if (mode == 1) b = 32'd0;
            else if (mode == 2) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            else if (mode == 3) b = 32'($urandom_range(1, 15));
            run_op("random", o, a, b);
            if ($urandom_range(0, 1) == 1) begin
                to_next_cycle();
                repeat ($urandom_range(0, 3)) to_next_cycle();
            end
        end
        to_next_cycle();
        repeat (3) to_next_cycle();

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
